// File: rtl/modem_line_event_monitor_if.sv
// Event drain channel of the modem line monitor: one timestamped line-change
// record per transfer, moved from producer (master) to consumer (slave).
interface modem_line_event_monitor_if #(
  parameter int NUM_LINES = 6,
  parameter int TS_WIDTH  = 16
);
  // valid/ready: a record moves on every clock edge where evt_valid_o and
  // evt_ready_i are both 1. While evt_valid_o=1 and evt_ready_i=0 the payload
  // holds still; valid never drops without a transfer, and ready is a don't-care
  // while valid=0. The payload reads 0 whenever valid=0.
  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic [NUM_LINES-1:0] evt_bits_o;
  logic [NUM_LINES-1:0] evt_delta_o;
  logic [TS_WIDTH-1:0]  evt_ts_o;

  modport master (
    output evt_valid_o,
    output evt_bits_o,
    output evt_delta_o,
    output evt_ts_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_bits_o,
    input  evt_delta_o,
    input  evt_ts_o,
    output evt_ready_i
  );
endinterface

// File: rtl/modem_line_event_monitor.sv
// Modem/handshake line monitor: synchronise and deglitch N async lines, queue a
// timestamped event per filtered change, and keep sticky delta/overflow status.
module modem_line_event_monitor #(
  parameter int NUM_LINES     = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int TS_WIDTH      = 16,
  parameter int DROP_WIDTH    = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_LINES-1:0]          modem_i,
  input  logic                          enable_i,
  input  logic                          clr_i,
  modem_line_event_monitor_if.master    evt,
  output logic [NUM_LINES-1:0]          status_o,
  output logic [NUM_LINES-1:0]          delta_o,
  output logic                          overflow_o,
  output logic [DROP_WIDTH-1:0]         drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * NUM_LINES + TS_WIDTH;

  localparam logic [CW-1:0]         C_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [LW-1:0]         L_FULL = LW'(FIFO_DEPTH);
  localparam logic [DROP_WIDTH-1:0] D_MAX  = '1;

  logic [NUM_LINES-1:0]  r_sync [SYNC_STAGES];
  logic [CW-1:0]         r_cnt  [NUM_LINES];
  logic [NUM_LINES-1:0]  r_filt;
  logic [TS_WIDTH-1:0]   r_ts;
  logic [NUM_LINES-1:0]  r_delta;
  logic                  r_ovf;
  logic [DROP_WIDTH-1:0] r_drop;
  logic [EW-1:0]         r_mem  [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;

  logic [NUM_LINES-1:0]  w_synced;
  logic [NUM_LINES-1:0]  w_filt_nxt;
  logic [CW-1:0]         w_cnt_nxt [NUM_LINES];
  logic [NUM_LINES-1:0]  w_change;
  logic [TS_WIDTH-1:0]   w_ts_evt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_not_empty;
  logic                  w_wr;
  logic                  w_drop;
  logic [EW-1:0]         w_head;

  // ---------------------------------------------------------------- sync chain
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= modem_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // A line is accepted on the FILTER_CYCLES-th consecutive cycle it disagrees
  // with the filtered level, so the count stops one short and the flip replaces it.
  always_comb begin
    w_filt_nxt = r_filt;
    for (int i = 0; i < NUM_LINES; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_synced[i] != r_filt[i]) begin
        if (r_cnt[i] == C_LAST) w_filt_nxt[i] = w_synced[i];
        else                    w_cnt_nxt[i]  = r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_filt <= '0;
      for (int i = 0; i < NUM_LINES; i++) r_cnt[i] <= '0;
    end else begin
      r_filt <= w_filt_nxt;
      for (int i = 0; i < NUM_LINES; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // ------------------------------------------------------------ event creation
  // The stamp is the counter value of the cycle in which the new status shows.
  assign w_change    = w_filt_nxt ^ r_filt;
  assign w_ts_evt    = r_ts + TS_WIDTH'(1);
  assign w_push      = (|w_change) & enable_i;
  assign w_not_empty = (r_level != '0);
  assign w_full      = (r_level == L_FULL);
  assign w_pop       = w_not_empty & evt.evt_ready_i;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_ts <= '0;
    else          r_ts <= r_ts + TS_WIDTH'(1);
  end

  // ---------------------------------------------------------------- event FIFO
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_filt_nxt, w_change, w_ts_evt};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ------------------------------------------------------------- sticky status
  // Clear first, then set, so a change or drop landing with clr_i survives it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_delta <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_delta <= (clr_i ? '0 : r_delta) | (enable_i ? w_change : '0);
      if (clr_i) begin
        r_ovf  <= w_drop;
        r_drop <= w_drop ? DROP_WIDTH'(1) : '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != D_MAX) r_drop <= r_drop + DROP_WIDTH'(1);
      end
    end
  end

  // ------------------------------------------------------------------- outputs
  assign w_head = r_mem[r_rd_ptr];

  assign evt.evt_valid_o = w_not_empty;
  assign evt.evt_bits_o  = w_not_empty ? w_head[EW-1 -: NUM_LINES]           : '0;
  assign evt.evt_delta_o = w_not_empty ? w_head[TS_WIDTH +: NUM_LINES]       : '0;
  assign evt.evt_ts_o    = w_not_empty ? w_head[TS_WIDTH-1:0]                : '0;

  assign status_o     = r_filt;
  assign delta_o      = r_delta;
  assign overflow_o   = r_ovf;
  assign drop_count_o = r_drop;
  assign fifo_level_o = r_level;

endmodule

// File: tb/tb_modem_line_event_monitor.sv
// Bench for modem_line_event_monitor: directed scenarios then random traffic,
// every cycle compared against a window-based reference model of the lines.
module tb_modem_line_event_monitor;
  localparam int N  = 6;
  localparam int S  = 2;
  localparam int F  = 4;
  localparam int D  = 8;
  localparam int TW = 16;
  localparam int DW = 8;
  localparam int EW = 2 * N + TW;
  localparam int HL = S + F;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      modem;
  logic              enable;
  logic              clr;
  logic [N-1:0]      status;
  logic [N-1:0]      delta;
  logic              ovf;
  logic [DW-1:0]     drop;
  logic [$clog2(D):0] level;

  modem_line_event_monitor_if #(.NUM_LINES(N), .TS_WIDTH(TW)) evt_if ();

  modem_line_event_monitor #(
    .NUM_LINES(N), .SYNC_STAGES(S), .FILTER_CYCLES(F),
    .FIFO_DEPTH(D), .TS_WIDTH(TW), .DROP_WIDTH(DW)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .modem_i      (modem),
    .enable_i     (enable),
    .clr_i        (clr),
    .evt          (evt_if.master),
    .status_o     (status),
    .delta_o      (delta),
    .overflow_o   (ovf),
    .drop_count_o (drop),
    .fifo_level_o (level)
  );

  // --------------------------------------------------------- reference model
  // A line flips once its last F synchronised samples all disagree with it.
  logic [N-1:0]  hist [HL];
  logic [N-1:0]  m_filt;
  logic [N-1:0]  m_nf;
  logic [N-1:0]  m_delta;
  logic          m_ovf;
  logic [DW-1:0] m_drop;
  logic [TW-1:0] m_ts;
  logic [EW-1:0] exp_q[$];
  bit            m_all;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HL; i++) hist[i] = '0;
      m_filt = '0; m_delta = '0; m_ovf = 1'b0; m_drop = '0; m_ts = '0;
      exp_q.delete();
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = modem;
      m_ts = m_ts + 1'b1;
      m_nf = m_filt;
      for (int l = 0; l < N; l++) begin
        m_all = 1'b1;
        for (int j = S; j < S + F; j++) if (hist[j][l] == m_filt[l]) m_all = 1'b0;
        if (m_all) m_nf[l] = ~m_filt[l];
      end
      if (exp_q.size() > 0 && evt_if.evt_ready_i) void'(exp_q.pop_front());
      if (clr) begin m_delta = '0; m_ovf = 1'b0; m_drop = '0; end
      if (m_nf != m_filt && enable) begin
        if (exp_q.size() < D) exp_q.push_back({m_nf, m_nf ^ m_filt, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 1'b1;
        end
        m_delta = m_delta | (m_nf ^ m_filt);
      end
      m_filt = m_nf;
    end
  end

  // -------------------------------------------------------------- scoreboard
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [EW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("valid",     64'(evt_if.evt_valid_o), 64'(exp_q.size() > 0));
    chk("head_bits", 64'(evt_if.evt_bits_o),  64'(head[EW-1 -: N]));
    chk("head_dlt",  64'(evt_if.evt_delta_o), 64'(head[TW +: N]));
    chk("head_ts",   64'(evt_if.evt_ts_o),    64'(head[TW-1:0]));
    chk("status",    64'(status),             64'(m_filt));
    chk("delta_o",   64'(delta),              64'(m_delta));
    chk("overflow",  64'(ovf),                64'(m_ovf));
    chk("drops",     64'(drop),               64'(m_drop));
    chk("level",     64'(level),              64'(exp_q.size()));
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; modem = '0; enable = 1'b1; clr = 1'b0; evt_if.evt_ready_i = 1'b0;
    step(2);
    chk("rst_valid", 64'(evt_if.evt_valid_o), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    rst = 1'b0;

    // cts rises in cycle 10 after release
    step(10);
    modem = 6'b010000;
    step(5);
    chk("cts_early", 64'(status), 64'd0);
    step(1);
    chk("cts_status", 64'(status), 64'h10);
    chk("cts_bits", 64'(evt_if.evt_bits_o), 64'h10);
    chk("cts_delta", 64'(evt_if.evt_delta_o), 64'h10);
    chk("cts_ts", 64'(evt_if.evt_ts_o), 64'd16);
    chk("cts_sticky", 64'(delta), 64'h10);
    evt_if.evt_ready_i = 1'b1; step(1); evt_if.evt_ready_i = 1'b0;
    step(3);

    // ri glitch of 3 cycles is rejected, 4 cycles is accepted both ways
    modem = 6'b010010; step(3); modem = 6'b010000; step(12);
    chk("glitch3_level", 64'(level), 64'd0);
    chk("glitch3_status", 64'(status), 64'h10);
    modem = 6'b010010; step(4); modem = 6'b010000; step(12);
    chk("glitch4_level", 64'(level), 64'd2);
    chk("glitch4_rise", 64'(evt_if.evt_bits_o), 64'h12);
    evt_if.evt_ready_i = 1'b1; step(1);
    chk("glitch4_fall", 64'(evt_if.evt_delta_o), 64'h02);
    step(1); evt_if.evt_ready_i = 1'b0;

    // overflow: 10 dcd toggles into an 8-deep FIFO
    pulse_clr();
    for (int k = 0; k < 10; k++) begin modem[0] = ~modem[0]; step(8); end
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_drops", 64'(drop), 64'd2);
    evt_if.evt_ready_i = 1'b1; step(8); evt_if.evt_ready_i = 1'b0;
    chk("ovf_drained", 64'(level), 64'd0);
    pulse_clr();
    chk("ovf_clr_flag", 64'(ovf), 64'd0);
    chk("ovf_clr_drops", 64'(drop), 64'd0);

    // full FIFO, push and pop on the same edge
    for (int k = 0; k < 8; k++) begin modem[0] = ~modem[0]; step(8); end
    modem[0] = ~modem[0]; step(5);
    evt_if.evt_ready_i = 1'b1; step(1); evt_if.evt_ready_i = 1'b0;
    chk("full_pp_level", 64'(level), 64'd8);
    chk("full_pp_drops", 64'(drop), 64'd0);
    chk("full_pp_ovf", 64'(ovf), 64'd0);
    evt_if.evt_ready_i = 1'b1; step(7);
    chk("full_pp_last_bits", 64'(evt_if.evt_bits_o), 64'h11);
    chk("full_pp_last_dlt", 64'(evt_if.evt_delta_o), 64'h01);
    step(1); evt_if.evt_ready_i = 1'b0;

    // multi-line change and clear racing a dsr change
    modem = '0; evt_if.evt_ready_i = 1'b1; step(10); evt_if.evt_ready_i = 1'b0;
    pulse_clr();
    modem = 6'b101001; step(6);
    chk("multi_level", 64'(level), 64'd1);
    chk("multi_delta", 64'(evt_if.evt_delta_o), 64'h29);
    modem = 6'b101101; step(5);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("clr_race_delta", 64'(delta), 64'h04);

    // reset with three queued events and all lines high
    modem = 6'b111111; step(8);
    chk("pre_rst_level", 64'(level), 64'd3);
    rst = 1'b1; step(1);
    chk("mid_rst_valid", 64'(evt_if.evt_valid_o), 64'd0);
    chk("mid_rst_status", 64'(status), 64'd0);
    chk("mid_rst_delta", 64'(delta), 64'd0);
    rst = 1'b0;
    step(5);
    chk("post_rst_quiet", 64'(evt_if.evt_valid_o), 64'd0);
    step(1);
    chk("post_rst_valid", 64'(evt_if.evt_valid_o), 64'd1);
    chk("post_rst_bits", 64'(evt_if.evt_bits_o), 64'h3F);
    chk("post_rst_delta", 64'(evt_if.evt_delta_o), 64'h3F);
    chk("post_rst_ts", 64'(evt_if.evt_ts_o), 64'd6);

    // random traffic: short and long holds, backpressure, enable, clear, reset
    for (int it = 0; it < 350; it++) begin
      if ($urandom_range(0, 3) == 0) modem = N'($urandom);
      else modem[$urandom_range(0, N - 1)] ^= 1'b1;
      enable = ($urandom_range(0, 5) != 0);
      evt_if.evt_ready_i = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 12) == 0);
      rst = ($urandom_range(0, 60) == 0);
      step(1);
      rst = 1'b0; clr = 1'b0;
      step($urandom_range(0, 11));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/modem_line_event_monitor.md
Name: modem_line_event_monitor

Overview:
Parametrised successor to the modem-line monitor. Synthesisable block on the UART core clock that samples N asynchronous modem/handshake lines. Each line is synchronised and deglitched. On every filtered change, the block queues a timestamped event carrying the new line vector and delta mask in a FIFO with valid/ready drain. It also provides sticky delta/overflow status for the register block and the interrupt logic.

Parameters:
NUM_LINES, 6, number of monitored lines (bit order on modem_i: [5]=rts, [4]=cts, [3]=dtr, [2]=dsr, [1]=ri, [0]=dcd at default)
SYNC_STAGES, 2, synchroniser flops per line (>=2)
FILTER_CYCLES, 4, consecutive cycles a synced level must differ from the filtered level before it is accepted (>=1)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
TS_WIDTH, 16, timestamp counter width
DROP_WIDTH, 8, dropped-event counter width

Ports:
wb_clk_i  in  1  core clock
wb_rst_i  in  1  reset; synchronous and active-high
modem_i  in  NUM_LINES  asynchronous line inputs
enable_i  in  1  event capture enable
clr_i  in  1  clears delta_o, overflow_o, drop_count_o
evt_valid_o  out  1  FIFO head valid
evt_ready_i  in  1  consumer accepts head
evt_bits_o  out  NUM_LINES  filtered line vector after the change
evt_delta_o  out  NUM_LINES  lines that changed (old XOR new)
evt_ts_o  out  TS_WIDTH  timestamp of the change
status_o  out  NUM_LINES  current filtered line vector
delta_o  out  NUM_LINES  sticky per-line change flags
overflow_o  out  1  sticky: an event was dropped
drop_count_o  out  DROP_WIDTH  dropped events, saturating
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- All state is cleared on wb_rst_i (sync, active-high), including mid-operation. On reset, all outputs are 0: synchroniser flops, filter counters, status_o, delta_o, overflow_o, drop_count_o, timestamp, FIFO pointers, evt_valid_o, and the evt_* head. The head outputs read 0 when the FIFO is empty.
- The reset transition itself generates no event. Because filtered lines start at 0, any line held at 1 through reset produces an event SYNC_STAGES+FILTER_CYCLES cycles after reset is released.
- Synchroniser: SYNC_STAGES-deep flop chain per line.
- Deglitch: each line has a counter of width $clog2(FILTER_CYCLES+1).
  - Counter cleared whenever synced == filtered.
  - Otherwise it increments.
  - When it reaches FILTER_CYCLES, filtered takes the synced value and the counter clears.
  - A pulse shorter than FILTER_CYCLES cycles at the synchroniser output never reaches status_o.
- Latency: an input held stable from before edge k changes status_o after edge k+SYNC_STAGES+FILTER_CYCLES-1, i.e. visible 6 cycles later at defaults.
- Timestamp: free-running counter, +1 every cycle, wraps from 2^TS_WIDTH-1 to 0. An event carries the timestamp value from the cycle in which status_o changes.
- Event generation: in any cycle where the filtered vector changes and enable_i=1, one push of {new, old^new, ts} is issued.
  - Simultaneous changes on several lines form one event with multiple delta bits.
  - With enable_i=0: filtering and status_o still track, but there is no push and delta_o is not set.
- delta_o[i] is set on every enabled change of line i and cleared by clr_i. If clr_i and a new change coincide, set wins for that line.
- FIFO: show-ahead. evt_valid_o=1 iff level>0, with the head presented on evt_*.
  - Pop when evt_valid_o && evt_ready_i.
  - Push latency: an event pushed into an empty FIFO appears on evt_valid_o the next cycle.
  - evt_* must be stable while evt_valid_o=1 and evt_ready_i=0.
  - Push and pop in the same cycle: level unchanged. This is legal even when full; the push is accepted.
  - Push when full with no pop: the event is discarded, overflow_o is set, and drop_count_o increments, saturating at 2^DROP_WIDTH-1.
  - clr_i clears overflow_o and drop_count_o. If a drop coincides with clr_i, the result is overflow_o=1 and drop_count_o=1.
- Pointers wrap modulo FIFO_DEPTH. The level counter distinguishes full from empty.
- evt_ready_i is ignored while empty.
- enable_i deasserting does not flush the FIFO; queued events remain drainable.

Test Plan:
- Reset, defaults, modem_i=0: drive modem_i=6'b010000 at cycle 10 → status_o=6'b010000 at cycle 16; one event with bits=010000, delta=010000, ts=16; delta_o[4]=1.
- Glitch: modem_i[1]=1 for 3 cycles, then 0 → no status change, no event, fifo_level_o=0. Repeat with a 4-cycle pulse → two events (rise and fall), delta=000010 each, ts differing by 4.
- Overflow: evt_ready_i=0, 10 toggles of modem_i[0] spaced 8 cycles apart → fifo_level_o=8, overflow_o=1, drop_count_o=2. Drain → 8 events in order with increasing ts. clr_i → overflow_o=0, drop_count_o=0.
- Full with same-cycle pop: FIFO at 8 and evt_ready_i=1 on the push cycle → no drop, level stays 8, new event is last out.
- Multi-line and clear race: modem_i changes 000000→101001 in one cycle → single event with delta=101001. clr_i asserted on the same cycle a dsr change lands → delta_o[2]=1, all other bits cleared.
- Reset mid-operation: 3 queued events, modem_i=111111, assert wb_rst_i for 1 cycle → all outputs 0 the next cycle. First new event arrives 6 cycles after release with bits=111111, delta=111111, ts=6.
